// File: rtl/anim_end_frame.sv
// anim_end_frame: winner end screen that fades in an upscaled indexed image over a blinking winner-coloured background.
module anim_end_frame #(
    parameter int          H_RES        = 320,
    parameter int          V_RES        = 240,
    parameter int          SCALE_SHIFT  = 1,
    parameter int          PIXEL_BITS   = 3,
    parameter int          FADE_BITS    = 4,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] P1_COLOR     = 24'h8b0403,
    parameter logic [23:0] P2_COLOR     = 24'h04038b
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_frame_tick,
    input  logic        i_is_p1_win,
    input  logic [9:0]  i_x,
    input  logic [8:0]  i_y,
    output logic [23:0] o_rgb,
    output logic        o_busy,
    output logic        o_done
);
    localparam int AW = $clog2(H_RES * V_RES);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FADE_BITS:0] FULL = {1'b1, {FADE_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, FADE, SHOW} state_t;

    // Built-in image: index pattern derived from the source address; palette entry 0 is transparent.
    function automatic logic [PIXEL_BITS-1:0] rom_rd(input logic [AW-1:0] a);
        return PIXEL_BITS'(a ^ (a >> 5));
    endfunction

    function automatic logic [23:0] pal_rd(input logic [PIXEL_BITS-1:0] i);
        logic [7:0] k;
        k = 8'(i);
        return {k * 8'd37, k * 8'd91, k * 8'd53};
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] c, input logic [FADE_BITS:0] l);
        logic [FADE_BITS+8:0] p;
        p = {{(FADE_BITS+1){1'b0}}, c} * {8'd0, l};
        return 8'(p >> FADE_BITS);
    endfunction

    state_t                 state_q, state_d;
    logic [FADE_BITS:0]     level_q, level_d;
    logic [BW-1:0]          blink_q, blink_d;
    logic                   phase_q, phase_d;
    logic                   p1_q, p1_d;
    logic [PIXEL_BITS-1:0]  idx1_q;
    logic                   rng1_q;
    logic [23:0]            col2_q;
    logic                   trans2_q;
    logic [23:0]            rgb_q;
    logic                   busy_q, done_q;

    logic [9:0]    sx;
    logic [8:0]    sy;
    logic          in_range;
    logic [AW-1:0] addr;
    logic [23:0]   base, bg, col3;

    assign sx       = i_x >> SCALE_SHIFT;
    assign sy       = i_y >> SCALE_SHIFT;
    assign in_range = ({22'd0, sx} < H_RES) && ({23'd0, sy} < V_RES);
    assign addr     = in_range ? AW'(sy) * AW'(H_RES) + AW'(sx) : '0;
    assign base     = p1_q ? P1_COLOR : P2_COLOR;
    assign bg       = phase_q ? {base[23:16] >> 1, base[15:8] >> 1, base[7:0] >> 1} : base;
    // Background is substituted in the last stage so winner/phase changes show up one cycle after they update.
    assign col3     = trans2_q ? bg : col2_q;
    assign o_rgb    = rgb_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        blink_d = blink_q;
        phase_d = phase_q;
        p1_d    = p1_q;
        if (i_start) begin
            state_d = FADE;
            level_d = '0;
            blink_d = '0;
            phase_d = 1'b0;
            p1_d    = i_is_p1_win;
        end else if (i_frame_tick && state_q == FADE) begin
            level_d = level_q + 1'b1;
            state_d = (level_d == FULL) ? SHOW : FADE;
        end else if (i_frame_tick && state_q == SHOW) begin
            blink_d = (blink_q == BW'(BLINK_FRAMES - 1)) ? '0 : blink_q + 1'b1;
            phase_d = phase_q ^ (blink_q == BW'(BLINK_FRAMES - 1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            p1_q     <= 1'b1;
            idx1_q   <= '0;
            rng1_q   <= 1'b0;
            col2_q   <= '0;
            trans2_q <= 1'b0;
            rgb_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            p1_q     <= p1_d;
            idx1_q   <= in_range ? rom_rd(addr) : '0;
            rng1_q   <= in_range;
            col2_q   <= rng1_q ? pal_rd(idx1_q) : '0;
            trans2_q <= rng1_q && (idx1_q == '0);
            rgb_q    <= {dim(col3[23:16], level_q), dim(col3[15:8], level_q), dim(col3[7:0], level_q)};
            busy_q   <= state_d == FADE;
            done_q   <= state_d == SHOW;
        end
    end
endmodule

// File: tb/tb_anim_end_frame.sv
// tb_anim_end_frame: randomized scenarios checked against a tick-counting behavioural model of the end screen.
module tb_anim_end_frame;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic        p1win = 1'b1;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic [23:0] rgb;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 idle, 1 fade, 2 show; ticks counted since the last start.
    int m_state = 0;
    int m_ticks = 0;
    bit m_p1 = 1'b1;

    anim_end_frame dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_frame_tick(tick),
        .i_is_p1_win(p1win), .i_x(x), .i_y(y),
        .o_rgb(rgb), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    function automatic int m_level();
        if (m_state == 0) return 0;
        return (m_ticks > 16) ? 16 : m_ticks;
    endfunction

    function automatic logic [23:0] m_bg();
        logic [23:0] b;
        b = m_p1 ? 24'h8b0403 : 24'h04038b;
        if (m_state == 2 && ((m_ticks - 16) / 30) % 2 == 1)
            b = {b[23:16] >> 1, b[15:8] >> 1, b[7:0] >> 1};
        return b;
    endfunction

    function automatic logic [23:0] exp_pix(input int xi, input int yi);
        int sx, sy, a, idx, lv;
        logic [23:0] c;
        sx = xi >> 1;
        sy = yi >> 1;
        if (sx >= 320 || sy >= 240) return 24'h0;
        a   = sy * 320 + sx;
        idx = (a % 8) ^ ((a / 32) % 8);
        c   = (idx == 0) ? m_bg() : {8'(idx * 37), 8'(idx * 91), 8'(idx * 53)};
        lv  = m_level();
        return {8'((c[23:16] * lv) >> 4), 8'((c[15:8] * lv) >> 4), 8'((c[7:0] * lv) >> 4)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (m_state != 0) begin
            m_ticks++;
            if (m_ticks >= 16) m_state = 2;
        end
    endtask

    task automatic do_start(input bit w);
        start = 1'b1;
        p1win = w;
        step();
        start = 1'b0;
        m_state = 1;
        m_ticks = 0;
        m_p1 = w;
    endtask

    task automatic settle();
        x = '0;
        y = '0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        tick = 1'b1;
        repeat (2) step();
        start = 1'b0;
        tick = 1'b0;
        n_cmp++;
        if ({rgb, busy, done} !== 26'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rgb=%h busy=%b done=%b want 0/0/0", rgb, busy, done);
        end
        rst = 1'b0;
        m_state = 0;
        m_ticks = 0;
        m_p1 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = 10'($urandom_range(0, 1023));
            y = 9'($urandom_range(0, 511));
            tick = 1'($urandom_range(0, 1));
            step();
            n_cmp++;
            if ({rgb, busy, done} !== 26'h0) begin
                n_bad++;
                $display("FAIL idle_scan: got rgb=%h busy=%b done=%b want 0/0/0", rgb, busy, done);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_scan(input int n, input bit seq, input int x0, input int y0);
        logic [23:0] q[$];
        logic [23:0] e;
        int xi, yi;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                xi = seq ? x0 + i : int'($urandom_range(0, 1023));
                yi = seq ? y0 : int'($urandom_range(0, 511));
                x = 10'(xi);
                y = 9'(yi);
                q.push_back(exp_pix(xi, yi));
            end
            step();
            if (i >= 2) begin
                e = q.pop_front();
                n_cmp++;
                if (rgb !== e) begin
                    n_bad++;
                    $display("FAIL scan_pixel: got %h want %h (state %0d ticks %0d)", rgb, e, m_state, m_ticks);
                end
            end
        end
    endtask

    task automatic test_fade();
        do_start(1'b1);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL fade_enter: got busy=%b done=%b want 1/0", busy, done);
        end
        settle();
        n_cmp++;
        if (rgb !== 24'h0) begin
            n_bad++;
            $display("FAIL fade_level0: got %h want 000000", rgb);
        end
        for (int t = 1; t <= 16; t++) begin
            do_tick();
            n_cmp++;
            if (busy !== (t < 16) || done !== (t == 16)) begin
                n_bad++;
                $display("FAIL fade_flags: tick %0d got busy=%b done=%b want %b/%b", t, busy, done, t < 16, t == 16);
            end
            settle();
            n_cmp++;
            if (rgb !== exp_pix(0, 0)) begin
                n_bad++;
                $display("FAIL fade_pixel: tick %0d got %h want %h", t, rgb, exp_pix(0, 0));
            end
            if (t == 8) begin
                n_cmp++;
                if (rgb !== 24'h450201) begin
                    n_bad++;
                    $display("FAIL fade_half: got %h want 450201", rgb);
                end
            end
        end
        n_cmp++;
        if (rgb !== 24'h8b0403) begin
            n_bad++;
            $display("FAIL fade_full: got %h want 8b0403", rgb);
        end
    endtask

    task automatic test_blink();
        do_start(1'b0);
        repeat (16) do_tick();
        settle();
        n_cmp++;
        if (rgb !== 24'h04038b) begin
            n_bad++;
            $display("FAIL blink_p2_full: got %h want 04038b", rgb);
        end
        repeat (29) do_tick();
        settle();
        n_cmp++;
        if (rgb !== 24'h04038b) begin
            n_bad++;
            $display("FAIL blink_before_wrap: got %h want 04038b", rgb);
        end
        do_tick();
        settle();
        n_cmp++;
        if (rgb !== 24'h020145 || rgb !== exp_pix(0, 0)) begin
            n_bad++;
            $display("FAIL blink_half: got %h want 020145", rgb);
        end
        test_scan(30, 1'b0, 0, 0);
        repeat (30) do_tick();
        settle();
        n_cmp++;
        if (rgb !== 24'h04038b) begin
            n_bad++;
            $display("FAIL blink_back: got %h want 04038b", rgb);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick = 1'b1;
        p1win = 1'b1;
        step();
        start = 1'b0;
        tick = 1'b0;
        m_state = 1;
        m_ticks = 0;
        m_p1 = 1'b1;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_flags: got busy=%b done=%b want 1/0", busy, done);
        end
        settle();
        n_cmp++;
        if (rgb !== 24'h0) begin
            n_bad++;
            $display("FAIL restart_black: got %h want 000000", rgb);
        end
        do_tick();
        settle();
        n_cmp++;
        if (rgb !== exp_pix(0, 0)) begin
            n_bad++;
            $display("FAIL restart_tick1: got %h want %h", rgb, exp_pix(0, 0));
        end
    endtask

    task automatic test_reset_mid(input int ticks);
        do_start(1'($urandom_range(0, 1)));
        repeat (ticks) do_tick();
        settle();
        rst = 1'b1;
        start = 1'b1;
        tick = 1'b1;
        step();
        start = 1'b0;
        tick = 1'b0;
        n_cmp++;
        if ({rgb, busy, done} !== 26'h0) begin
            n_bad++;
            $display("FAIL reset_mid_%0d: got rgb=%h busy=%b done=%b want 0/0/0", ticks, rgb, busy, done);
        end
        rst = 1'b0;
        m_state = 0;
        m_ticks = 0;
        m_p1 = 1'b1;
        test_scan(8, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) do_start(1'($urandom_range(0, 1)));
            else if (r < 14) do_tick();
            else step();
            n_cmp++;
            if (busy !== (m_state == 1) || done !== (m_state == 2)) begin
                n_bad++;
                $display("FAIL random_flags: got busy=%b done=%b want %b/%b", busy, done, m_state == 1, m_state == 2);
            end
            if (k % 4 == 0) test_scan(6, 1'b0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_fade();
        test_scan(40, 1'b1, int'($urandom_range(0, 500)), int'($urandom_range(0, 479)));
        test_scan(40, 1'b1, 620, int'($urandom_range(0, 479)));
        test_scan(60, 1'b0, 0, 0);
        test_blink();
        test_back_to_back();
        test_reset_mid(5);
        test_reset_mid(20);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/anim_end_frame.md
ANIM_END_FRAME -- requirements
Module: anim_end_frame

Interface
REQ-001 SHALL have parameter H_RES, 320, source image width in pixels.
REQ-002 SHALL have parameter V_RES, 240, source image height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, 1, log2 of the upscale factor from source to screen coordinates.
REQ-004 SHALL have parameter PIXEL_BITS, 3, palette index width; palette has 2^PIXEL_BITS entries.
REQ-005 SHALL have parameter FADE_BITS, 4, brightness fraction width; full brightness level = 2^FADE_BITS.
REQ-006 SHALL have parameter BLINK_FRAMES, 30, frame ticks per background blink half-period in SHOW.
REQ-007 SHALL have parameters P1_COLOR, 24'h8b0403, and P2_COLOR, 24'h04038b, winner background colours.
REQ-008 i_clk  input  1  single clock; all state updates on rising edge.
REQ-009 i_rst  input  1  reset; synchronous and active-high.
REQ-010 i_start  input  1  one-cycle pulse: latch winner, begin fade-in.
REQ-011 i_frame_tick  input  1  one-cycle pulse once per displayed frame (vertical blank).
REQ-012 i_is_p1_win  input  1  winner select, sampled only when i_start=1.
REQ-013 i_x  input  10  screen column; i_y  input  9  screen row.
REQ-014 o_rgb  output  24  pixel colour {R,G,B}, 8 bits each.
REQ-015 o_busy  output  1  high in FADE; o_done  output  1  high in SHOW.

Function
REQ-016 SHALL hold a ROM of H_RES*V_RES PIXEL_BITS-bit indices and a 2^PIXEL_BITS x 24-bit palette, both preloaded from files and read-only.
REQ-017 SHALL compute source address = (i_y>>SCALE_SHIFT)*H_RES + (i_x>>SCALE_SHIFT), width ceil(log2(H_RES*V_RES)).
REQ-018 SHALL flag in_range when (i_x>>SCALE_SHIFT)<H_RES and (i_y>>SCALE_SHIFT)<V_RES; out-of-range pixels SHALL output 24'h000000 and never index the ROM beyond its depth.
REQ-019 Pipeline: stage 1 registers ROM index and in_range; stage 2 registers palette colour (index 0 = transparent -> current background colour); stage 3 registers brightness-scaled o_rgb.
REQ-020 Latency from i_x/i_y to o_rgb SHALL be exactly 3 cycles, one new pixel accepted every cycle, no stalls.
REQ-021 Brightness: each 8-bit channel out = (channel * level) >> FADE_BITS, level in 0..2^FADE_BITS (FADE_BITS+1 bits); level=2^FADE_BITS SHALL pass channel unchanged.
REQ-022 FSM states: IDLE, FADE, SHOW.
REQ-023 IDLE: level=0 (o_rgb black); i_start -> FADE with level=0, winner latched.
REQ-024 FADE: each i_frame_tick increments level by 1; the tick on which level reaches 2^FADE_BITS moves to SHOW.
REQ-025 SHOW: level held at 2^FADE_BITS; blink counter counts i_frame_tick 0..BLINK_FRAMES-1, wraps to 0 and toggles blink phase on wrap.
REQ-026 Background SHALL be winner colour when blink phase=0, and winner colour with each channel halved (>>1) when phase=1; phase=0 on entering SHOW.
REQ-027 i_start in FADE or SHOW SHALL restart: state FADE, level=0, blink counter/phase cleared, winner re-latched.
REQ-028 i_start and i_frame_tick in same cycle: i_start SHALL win; level=0 after that edge.
REQ-029 FSM/level/winner changes SHALL take effect in stage 3 on the cycle after the update edge; in-flight pixels are not re-coloured retroactively beyond that.
REQ-030 o_busy, o_done SHALL be registered decodes of state.

Reset
REQ-031 On i_rst=1 at a clock edge: state IDLE, level 0, blink counter 0, phase 0, winner P1, all pipeline registers 0, o_rgb=24'h000000, o_busy=0, o_done=0.
REQ-032 i_rst SHALL override i_start and i_frame_tick in the same cycle, including mid-FADE and mid-SHOW.

Verification
REQ-033 Reset then scan any coordinates without i_start -> o_rgb=0, o_busy=0, o_done=0 for all cycles.
REQ-034 i_start with i_is_p1_win=1, 16 ticks (FADE_BITS=4) -> o_busy=1 through tick 15, o_done=1 after tick 16; transparent pixel = 24'h8b0403; at level 8 it reads 24'h450201.
REQ-035 In SHOW, step i_x by one per cycle -> o_rgb matches golden ROM/palette model delayed exactly 3 cycles; i_x=640 (out of range) -> 24'h000000.
REQ-036 In SHOW with P2 winner, 30 ticks -> transparent pixels change 24'h04038b to 24'h020145; 30 more ticks -> back to 24'h04038b.
REQ-037 i_start coincident with i_frame_tick during SHOW -> o_done=0, o_busy=1, level 0 (black) next frame; i_rst mid-FADE -> all outputs 0 next cycle.
